// File: rtl/prog_mem.sv
// Program memory with a RUN/LOAD FSM: the CPU fetches in RUN, a loader writes in LOAD.
// Optional macro PROG_MEM_PARITY_EN adds a stored even-parity bit per word and a sticky par_err output.
module prog_mem #(
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_BITS-1:0]  fetch_addr,
  output logic [WORD_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  input  logic                  load_mode,
  input  logic                  load_wr,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic [ADDR_BITS:0]    load_count
`ifdef PROG_MEM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = WORD_WIDTH + 1;
`else
  localparam int MEM_W = WORD_WIDTH;
`endif
  localparam logic [ADDR_BITS:0] COUNT_MAX = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic                    load_ready_s;
  logic                    fetch_acc_s;
  logic                    wr_acc_s;
  logic [MEM_W-1:0]        mem_wdata_s;
  logic [MEM_W-1:0]        mem_rdata_s;
  logic [WORD_WIDTH-1:0]   fetch_data_q;
  logic                    fetch_valid_q;
  logic [ADDR_BITS:0]      load_count_q;

  // Zero initial contents double as the FPGA bitstream init; reset never touches memory.
  logic [MEM_W-1:0] mem_q [DEPTH] = '{default: '0};

`ifdef PROG_MEM_PARITY_EN
  logic par_err_q;

  function automatic logic even_parity(input logic [WORD_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: state simply follows the load_mode level one edge later
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (load_mode) state_d = ST_LOAD;
        else           state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (load_mode) state_d = ST_LOAD;
        else           state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output/strobe decode from current state
  always_comb begin
    load_ready_s = (state_q == ST_LOAD);
    fetch_acc_s  = (state_q == ST_RUN) && fetch_req && !rst;
    wr_acc_s     = (state_q == ST_LOAD) && load_wr && !rst;
  end

`ifdef PROG_MEM_PARITY_EN
  assign mem_wdata_s = {even_parity(load_data), load_data};
`else
  assign mem_wdata_s = load_data;
`endif
  assign mem_rdata_s = mem_q[fetch_addr];

  // Memory write port
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[load_addr] <= mem_wdata_s;
    end
  end

  // Fetch data/valid registers; data holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_acc_s;
      if (fetch_acc_s) begin
        fetch_data_q <= mem_rdata_s[WORD_WIDTH-1:0];
      end
    end
  end

  // Words-written counter: cleared on entry to LOAD, saturates at the memory depth
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count_q <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_LOAD)) begin
      load_count_q <= '0;
    end else if (wr_acc_s && (load_count_q != COUNT_MAX)) begin
      load_count_q <= load_count_q + {{ADDR_BITS{1'b0}}, 1'b1};
    end
  end

`ifdef PROG_MEM_PARITY_EN
  // Sticky parity error, flagged the cycle after a mismatching fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (fetch_acc_s &&
                 (even_parity(mem_rdata_s[WORD_WIDTH-1:0]) != mem_rdata_s[WORD_WIDTH])) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`endif

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign load_ready  = load_ready_s;
  assign load_count  = load_count_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the program memory.
module tb_prog_mem;

  localparam int WW    = 24;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [WW-1:0] fetch_data;
  logic          fetch_valid;
  logic          load_mode;
  logic          load_wr;
  logic [AW-1:0] load_addr;
  logic [WW-1:0] load_data;
  logic          load_ready;
  logic [AW:0]   load_count;
`ifdef PROG_MEM_PARITY_EN
  logic          par_err;
`endif

  always #5 clk = ~clk;

  prog_mem #(.WORD_WIDTH(WW), .ADDR_BITS(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .load_mode  (load_mode),
    .load_wr    (load_wr),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_count (load_count)
`ifdef PROG_MEM_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  // Reference model state
  logic [WW-1:0] m_mem [DEPTH];
  bit            m_in_load;
  bit            m_fv;
  logic [WW-1:0] m_fd;
  int            m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_in_load = 1'b0;
      m_fv      = 1'b0;
      m_fd      = '0;
      m_cnt     = 0;
    end else begin
      if (!m_in_load && fetch_req) begin
        m_fd = m_mem[fetch_addr];
        m_fv = 1'b1;
      end else begin
        m_fv = 1'b0;
      end
      if (m_in_load && load_wr) begin
        m_mem[load_addr] = load_data;
        if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
      end
      if (!m_in_load && load_mode) m_cnt = 0;
      m_in_load = load_mode;
    end
    #1;
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
    check_eq("fetch_data",  {8'd0, fetch_data},   {8'd0, m_fd});
    check_eq("load_ready",  {31'd0, load_ready},  {31'd0, m_in_load});
    check_eq("load_count",  {23'd0, load_count},  m_cnt);
  endtask

  task automatic idle();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_wr    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_in_load = 1'b0;
    m_fv      = 1'b0;
    m_fd      = '0;
    m_cnt     = 0;
    rst       = 1'b1;
    load_mode = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Fetch from never-written memory returns zero
    fetch_req = 1'b1; fetch_addr = 8'd5;
    step();
    check_eq("pwrup_valid", {31'd0, fetch_valid}, 32'd1);
    check_eq("pwrup_data",  {8'd0, fetch_data},   32'd0);
    idle();

    // Load two words, then fetch them back-to-back
    load_mode = 1'b1;
    step();
    load_wr = 1'b1; load_addr = 8'd1; load_data = 24'h0A0005;
    step();
    load_addr = 8'd2; load_data = 24'h0B0001;
    step();
    idle();
    load_mode = 1'b0;
    step();
    fetch_req = 1'b1; fetch_addr = 8'd1;
    step();
    check_eq("load_word1", {8'd0, fetch_data}, 32'h0A0005);
    fetch_addr = 8'd2;
    step();
    check_eq("load_word2", {8'd0, fetch_data}, 32'h0B0001);
    check_eq("load_cnt2",  {23'd0, load_count}, 32'd2);

    // Fetch in the cycle load_mode rises is served; fetches in LOAD are ignored
    load_mode = 1'b1; fetch_addr = 8'd1;
    step();
    check_eq("fetch_at_entry", {8'd0, fetch_data}, 32'h0A0005);
    fetch_addr = 8'd2;
    repeat (3) begin
      step();
      check_eq("load_novalid", {31'd0, fetch_valid}, 32'd0);
      check_eq("load_hold",    {8'd0, fetch_data},   32'h0A0005);
    end
    idle();
    load_mode = 1'b0;
    step();

    // Writes in RUN are ignored
    load_wr = 1'b1; load_addr = 8'd3; load_data = 24'hFFFFFF;
    step();
    idle();
    fetch_req = 1'b1; fetch_addr = 8'd3;
    step();
    check_eq("run_wr_ignored", {8'd0, fetch_data}, 32'd0);
    idle();

    // Write in the final LOAD cycle while load_mode has already dropped
    load_mode = 1'b1;
    step();
    load_mode = 1'b0; load_wr = 1'b1; load_addr = 8'd20; load_data = 24'h123456;
    step();
    idle();
    fetch_req = 1'b1; fetch_addr = 8'd20;
    step();
    check_eq("last_cycle_wr", {8'd0, fetch_data}, 32'h123456);
    idle();

    // Mid-load reset: state back to RUN, count cleared, words retained
    load_mode = 1'b1;
    step();
    load_wr = 1'b1; load_addr = 8'd10; load_data = 24'hC0FFEE;
    step();
    load_addr = 8'd11; load_data = 24'h00BEEF;
    step();
    load_addr = 8'd12; load_data = 24'hDEAD00;
    rst = 1'b1; load_mode = 1'b0;
    step();
    check_eq("rst_ready", {31'd0, load_ready}, 32'd0);
    check_eq("rst_count", {23'd0, load_count}, 32'd0);
    rst = 1'b0;
    idle();
    fetch_req = 1'b1; fetch_addr = 8'd10;
    step();
    check_eq("rst_keep10", {8'd0, fetch_data}, 32'hC0FFEE);
    fetch_addr = 8'd11;
    step();
    check_eq("rst_keep11", {8'd0, fetch_data}, 32'h00BEEF);
    fetch_addr = 8'd12;
    step();
    check_eq("rst_blocks_wr", {8'd0, fetch_data}, 32'd0);
    idle();

    // Counter saturation, including rewrites of the same addresses
    load_mode = 1'b1;
    step();
    load_wr = 1'b1;
    for (int i = 0; i < 260; i++) begin
      load_addr = 8'(i);
      load_data = 24'($urandom);
      step();
    end
    check_eq("cnt_saturate", {23'd0, load_count}, 32'd256);
    idle();
    load_mode = 1'b0;
    step();
    step();
    check_eq("cnt_hold_run", {23'd0, load_count}, 32'd256);

    // Randomized traffic with occasional resets and mode changes
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 29) == 0) load_mode = ~load_mode;
      fetch_req  = 1'($urandom);
      load_wr    = 1'($urandom);
      fetch_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      load_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      load_data  = 24'($urandom);
      step();
    end
    rst = 1'b0;
    load_mode = 1'b0;
    idle();
    step();

`ifdef PROG_MEM_PARITY_EN
    // Corrupt the stored parity of word 4 and confirm the sticky error
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("par_clear", {31'd0, par_err}, 32'd0);
    dut.mem_q[4][WW] = ~dut.mem_q[4][WW];
    fetch_req = 1'b1; fetch_addr = 8'd4;
    step();
    check_eq("par_set", {31'd0, par_err}, 32'd1);
    idle();
    repeat (3) step();
    check_eq("par_sticky", {31'd0, par_err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("par_rst", {31'd0, par_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
